rv_mem_if: RTL and testbench
============================

# rv_mem_if

Memory interface unit between the multicycle RISC-V control/datapath and a variable-latency word memory. It accepts one-cycle access strobes (instruction fetch, load, store) from the core and runs a valid/ready handshake toward memory. It returns read data with a one-cycle completion pulse and holds the core stalled via `cpu_busy` while the access is in flight. Misaligned and timed-out accesses are rejected with an error flag instead of hanging the core.

## Interface
- `TIMEOUT`, default 64: maximum `BUS` cycles waited for `mem_ready` before aborting; legal range 2..1023.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `cpu_req` input 1: access strobe, sampled only in `IDLE`.
- `cpu_we` input 1: 1 = store, 0 = read (fetch or load); sampled with `cpu_req`.
- `cpu_addr` input 32: byte address; sampled with `cpu_req`.
- `cpu_wdata` input 32: store data; sampled with `cpu_req`.
- `cpu_busy` output 1: high whenever state is not `IDLE`; the core stalls on it.
- `cpu_done` output 1: one-cycle completion pulse.
- `cpu_err` output 1: valid only while `cpu_done` is high; 1 = misaligned or timeout.
- `cpu_rdata` output 32: last successfully read word.
- `mem_valid` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_addr` output 32: word-aligned address.
- `mem_wdata` output 32: bus write data.
- `mem_ready` input 1: memory accepts or completes the access in this cycle.
- `mem_rdata` input 32: read data, valid when `mem_ready` is high and `mem_we` is 0.

## Operation
- FSM states: `IDLE`, `BUS`, `RESP`.
- `IDLE`, `cpu_req` high:
  - Capture `cpu_we`, `cpu_addr`, `cpu_wdata` into internal registers.
  - If `cpu_addr[1:0] != 0`, go to `RESP` with the error bit set. No bus cycle is issued.
  - Otherwise clear the timeout counter and go to `BUS`.
- `IDLE`, `cpu_req` low: stay in `IDLE`.
- `BUS`:
  - `mem_valid=1`.
  - `mem_we`, `mem_addr`, `mem_wdata` come from the captured registers.
  - `mem_addr` is `{addr[31:2],2'b00}`.
  - All four bus outputs stay stable until `mem_ready` is seen.
- `BUS`, `mem_ready` high:
  - For a read, load `cpu_rdata` with `mem_rdata`.
  - Clear the error bit and go to `RESP`.
- `BUS`, `mem_ready` low: increment the counter. The counter is 10 bits wide and saturates, so it never wraps.
  - When the counter reaches `TIMEOUT-1` with `mem_ready` still low, set the error bit and go to `RESP`. This makes `TIMEOUT` bus cycles in total.
  - `mem_valid` drops on the next edge.
- `RESP`: `cpu_done=1`, `cpu_err` = error bit, then go to `IDLE` unconditionally.
- `cpu_req` while `cpu_busy` is high: ignored; no queuing.
- `cpu_rdata` is unchanged by stores, misaligned accesses and timeouts.
- `mem_ready` outside `BUS`: ignored.
- `mem_ready` arriving in the same cycle the timeout fires: counts as success; `mem_ready` has priority.
- Reset values: state `IDLE`; `cpu_busy`, `cpu_done`, `cpu_err`, `mem_valid`, `mem_we` all 0; `cpu_rdata`, `mem_addr`, `mem_wdata` all 0; counter 0.
- All outputs are registered or decoded from state plus registers only. There is no combinational path from `cpu_*` inputs to `mem_*` outputs.

## Timing
- `cpu_req` sampled at edge N, aligned access: `mem_valid` is high from cycle N+1.
- `mem_ready` sampled high at edge N+k (k≥1): `cpu_done` is high in cycle N+k+1, `cpu_busy` is low from cycle N+k+2.
- Minimum latency, strobe edge to `cpu_done` cycle: 2 cycles. A new `cpu_req` is accepted at edge N+k+2 at the earliest.
- Misaligned access: `cpu_done` and `cpu_err` high in cycle N+1; `mem_valid` is never asserted.
- Timeout: `mem_valid` is high for exactly `TIMEOUT` cycles, then `cpu_done`/`cpu_err` is high in the following cycle.
- `rst` high at any edge: every output takes its reset value on that edge, including mid-`BUS` (`mem_valid` drops and no `cpu_done` is produced). The aborted transfer is not resumed.

## Test plan
- Read, zero wait: `cpu_req`, `cpu_we=0`, `cpu_addr=0x100`; memory returns `mem_ready=1` on the first `BUS` cycle with `mem_rdata=0xDEADBEEF` -> `mem_addr=0x100`; `cpu_done=1`, `cpu_err=0` two cycles after the strobe; `cpu_rdata=0xDEADBEEF`.
- Store, 5 wait cycles: `cpu_addr=0x204`, `cpu_wdata=0x12345678`, `cpu_we=1` -> `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata` stable for 6 cycles; `cpu_done` 7 cycles after the strobe; `cpu_rdata` unchanged.
- Misaligned: `cpu_addr=0x102` -> `mem_valid` stays 0; `cpu_done=1`, `cpu_err=1` in the next cycle.
- Timeout, `TIMEOUT=4`, `mem_ready` held 0 -> `mem_valid` high for exactly 4 cycles; then `cpu_done=1`, `cpu_err=1`; FSM back to `IDLE`.
- Ready at timeout, `TIMEOUT=4`, `mem_ready=1` on the 4th `BUS` cycle with `mem_rdata=0xA5A5A5A5` -> `cpu_err=0`, `cpu_rdata=0xA5A5A5A5`.
- Back-to-back and reset:
  - Strobe `cpu_req` every cycle -> only strobes in `IDLE` are accepted.
  - Assert `rst` in the 2nd `BUS` cycle -> `mem_valid=0` and `cpu_busy=0` the next cycle; no `cpu_done`; all outputs at reset values.

Source files
------------

// File: rtl/rv_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_if
// Description : Memory interface unit between the multicycle RISC-V core and
//               a variable-latency word memory. Accepts one-cycle access
//               strobes from the core, runs a valid/ready handshake toward
//               memory, and returns a one-cycle completion pulse with an
//               error flag for misaligned or timed-out accesses.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   cpu_req    : access strobe, sampled only while idle
//   cpu_we     : 1 = store, 0 = read (fetch or load)
//   cpu_addr   : byte address
//   cpu_wdata  : store data
//   cpu_busy   : high while an access is in flight (core stalls on it)
//   cpu_done   : one-cycle completion pulse
//   cpu_err    : misaligned / timeout flag, meaningful only with cpu_done
//   cpu_rdata  : last successfully read word
//   mem_valid  : bus request
//   mem_we     : bus write enable
//   mem_addr   : word-aligned bus address
//   mem_wdata  : bus write data
//   mem_ready  : memory accepts/completes the access this cycle
//   mem_rdata  : read data, valid with mem_ready on reads
//
// Revision    : 1.0 - initial release
// ============================================================================
module rv_mem_if #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // Last counter value before the access is abandoned: the counter starts
    // at 0 on the first bus cycle, so reaching TIMEOUT-1 without mem_ready
    // means TIMEOUT bus cycles have elapsed.
    localparam logic [9:0] c_CNT_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] c_CNT_MAX  = 10'h3FF;

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_BUS  = 2'd1,
        c_RESP = 2'd2
    } state_t;

    state_t      r_state;

    // Captured access. Only the word part of the address is kept because
    // misalignment is resolved at capture time and never reaches the bus.
    logic        r_we;
    logic [29:0] r_addr_word;
    logic [31:0] r_wdata;

    logic        r_err;
    logic [9:0]  r_cnt;
    logic [31:0] r_rdata;

    // Registered status flags, updated together with the state so every
    // output is a flop (or a flop AND flop) rather than decoded from inputs.
    logic        r_busy;
    logic        r_done;
    logic        r_mem_valid;

    logic        w_misaligned;

    assign w_misaligned = (cpu_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_we        <= 1'b0;
            r_addr_word <= 30'd0;
            r_wdata     <= 32'd0;
            r_err       <= 1'b0;
            r_cnt       <= 10'd0;
            r_rdata     <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (cpu_req) begin
                        r_we        <= cpu_we;
                        r_addr_word <= cpu_addr[31:2];
                        r_wdata     <= cpu_wdata;
                        r_busy      <= 1'b1;
                        if (w_misaligned) begin
                            // Rejected without touching the bus.
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= c_RESP;
                        end else begin
                            r_err       <= 1'b0;
                            r_cnt       <= 10'd0;
                            r_mem_valid <= 1'b1;
                            r_state     <= c_BUS;
                        end
                    end
                end

                c_BUS: begin
                    // mem_ready is checked before the timeout so a response
                    // arriving on the final permitted cycle still succeeds.
                    if (mem_ready) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_err       <= 1'b0;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_RESP;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_err       <= 1'b1;
                        r_mem_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_RESP;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end

                c_RESP: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end

                default: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_mem_valid <= 1'b0;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign cpu_busy  = r_busy;
    assign cpu_done  = r_done;
    // The error bit is only meaningful during the completion pulse.
    assign cpu_err   = r_done & r_err;
    assign cpu_rdata = r_rdata;

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_we;
    assign mem_addr  = {r_addr_word, 2'b00};
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_mem_if
// Description : Self-checking bench for rv_mem_if. One instance uses the
//               default timeout, a second uses TIMEOUT=4 for the timeout
//               corner cases. Table vectors, randomized accesses against a
//               transaction-level model, and hand-written sequences for
//               back-to-back strobes and mid-transfer reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_mem_if;

    localparam int T_MAIN  = 64;
    localparam int T_SMALL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic        mready = 1'b0;
    logic [31:0] mrdata = 32'd0;
    bit          sel = 1'b0;

    // Per-instance connections
    logic        a_req, b_req, a_ready, b_ready;
    logic        a_busy, a_done, a_err, a_valid, a_we;
    logic        b_busy, b_done, b_err, b_valid, b_we;
    logic [31:0] a_rdata, a_addr, a_wdata, b_rdata, b_addr, b_wdata;

    assign a_req   = cpu_req & ~sel;
    assign b_req   = cpu_req &  sel;
    assign a_ready = mready  & ~sel;
    assign b_ready = mready  &  sel;

    // Selected-instance view
    logic        s_busy, s_done, s_err, s_valid, s_we;
    logic [31:0] s_rdata, s_addr, s_wdata;
    assign s_busy  = sel ? b_busy  : a_busy;
    assign s_done  = sel ? b_done  : a_done;
    assign s_err   = sel ? b_err   : a_err;
    assign s_valid = sel ? b_valid : a_valid;
    assign s_we    = sel ? b_we    : a_we;
    assign s_rdata = sel ? b_rdata : a_rdata;
    assign s_addr  = sel ? b_addr  : a_addr;
    assign s_wdata = sel ? b_wdata : a_wdata;

    rv_mem_if #(.TIMEOUT(T_MAIN)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(a_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(a_busy), .cpu_done(a_done), .cpu_err(a_err), .cpu_rdata(a_rdata),
        .mem_valid(a_valid), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_ready(a_ready), .mem_rdata(mrdata)
    );

    rv_mem_if #(.TIMEOUT(T_SMALL)) dut_t4 (
        .clk(clk), .rst(rst),
        .cpu_req(b_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(b_busy), .cpu_done(b_done), .cpu_err(b_err), .cpu_rdata(b_rdata),
        .mem_valid(b_valid), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_ready(b_ready), .mem_rdata(mrdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete access. Expected outcome (error, latency from strobe edge
    // to the done cycle, resulting read register) is supplied by the caller.
    // Busy-time cpu_req pulses and out-of-window mem_ready pulses are thrown
    // in to confirm they are ignored.
    task automatic run_access(input bit s, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int waits,
                              input logic [31:0] data, input bit exp_err,
                              input int exp_lat, input logic [31:0] exp_rdata);
        int          nvalid;
        logic [31:0] aw;
        nvalid = exp_lat - 1;
        aw     = {addr[31:2], 2'b00};
        sel    = s;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        mready = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= exp_lat; c++) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            if (c <= nvalid) begin
                chk("bus_flags", 32'({s_valid, s_busy, s_done, s_err}), 32'b1100);
                chk("bus_addr",  s_addr,  aw);
                chk("bus_wdata", s_wdata, wdata);
                chk("bus_we",    32'(s_we), 32'(we));
                mready = (c == waits + 1);
                mrdata = mready ? data : $urandom;
            end else begin
                chk("resp_flags", 32'({s_valid, s_busy, s_done, s_err}),
                    32'({3'b011, exp_err}));
                chk("resp_rdata", s_rdata, exp_rdata);
                mready = 1'($urandom_range(0, 1));
                mrdata = $urandom;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        chk("idle_flags", 32'({s_valid, s_busy, s_done, s_err}), 32'b0000);
        chk("idle_rdata", s_rdata, exp_rdata);
        mready = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] data;
        bit          err;
        int          lat;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] ra, rw, rd;
    bit          rwe, re;
    int          rwaits, rlat, next_free, ndone, last_acc;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    initial begin
        // Read zero-wait, store with 5 waits, misaligned read/store,
        // then two more reads with short waits (default timeout instance).
        vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,          0, 32'hDEAD_BEEF, 1'b0, 2, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0204, 32'h1234_5678,  5, 32'h0BAD_0BAD, 1'b0, 7, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0102, 32'h0,          0, 32'h1111_1111, 1'b1, 1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h0000_0203, 32'hFFFF_0000,  0, 32'h2222_2222, 1'b1, 1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,          2, 32'h0F0F_1234, 1'b0, 4, 32'h0F0F_1234};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0,          1, 32'h8000_0001, 1'b0, 3, 32'h8000_0001};

        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_flags", 32'({s_valid, s_busy, s_done, s_err, s_we}), 32'd0);
            chk("rst_addr",  s_addr,  32'd0);
            chk("rst_wdata", s_wdata, 32'd0);
            chk("rst_rdata", s_rdata, 32'd0);
        end

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            run_access(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                       vecs[i].data, vecs[i].err, vecs[i].lat, vecs[i].rdata);
        end
        model_rdata[0] = vecs[5].rdata;

        // Timeout on the small instance: no ready at all -> 4 bus cycles, error
        run_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 10, 32'h3333_3333, 1'b1, 5, model_rdata[1]);
        // Ready on the 4th (last) bus cycle wins over the timeout
        model_rdata[1] = 32'hA5A5_A5A5;
        run_access(1'b1, 1'b0, 32'h0000_0504, 32'h0, 3, 32'hA5A5_A5A5, 1'b0, 5, model_rdata[1]);
        // Store that times out leaves the read register alone
        run_access(1'b1, 1'b1, 32'h0000_0508, 32'h7777_7777, 4, 32'h4444_4444, 1'b1, 5, model_rdata[1]);

        // Randomized accesses against the transaction model
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
            else if (ra[1:0] == 2'b00)     ra[1:0] = 2'b01;
            rwe    = 1'($urandom_range(0, 1));
            rw     = $urandom;
            rd     = $urandom;
            rwaits = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(0, 6));
            if (ra[1:0] != 2'b00) begin
                re = 1'b1; rlat = 1;
            end else if (rwaits + 1 <= T_MAIN) begin
                re = 1'b0; rlat = rwaits + 2;
                if (!rwe) model_rdata[0] = rd;
            end else begin
                re = 1'b1; rlat = T_MAIN + 1;
            end
            run_access(1'b0, rwe, ra, rw, rwaits, rd, re, rlat, model_rdata[0]);
        end

        // Back-to-back strobes with zero-wait memory: each accepted access
        // occupies strobe edge + bus cycle + response cycle, so the next
        // acceptance is three edges later.
        sel = 1'b0;
        @(negedge clk);
        ndone = 0; next_free = 0; last_acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (i >= next_free) begin
                exp_q.push_back(32'h300 + 32'(4 * i));
                next_free = i + 3;
                last_acc  = i;
            end
        end
        for (int j = 0; j < 16; j++) begin
            if (j >= 1) begin
                if (s_valid) got_q.push_back(s_addr);
                if (s_done)  ndone++;
            end
            cpu_req  = (j < 12);
            cpu_we   = 1'b0;
            cpu_addr = 32'h300 + 32'(4 * j);
            mready   = 1'b1;
            mrdata   = 32'hC0DE_0000 | 32'(j);
            @(negedge clk);
        end
        cpu_req = 1'b0; mready = 1'b0;
        chk("b2b_count", 32'(got_q.size()), 32'(exp_q.size()));
        chk("b2b_done",  32'(ndone),        32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            chk("b2b_addr", (k < got_q.size()) ? got_q[k] : 32'hFFFF_FFFF, exp_q[k]);
        end
        model_rdata[0] = 32'hC0DE_0000 | 32'(last_acc + 1);
        chk("b2b_rdata", s_rdata, model_rdata[0]);

        // Reset in the second bus cycle of a store
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h55AA_55AA;
        mready = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("rstbus_v1", 32'(s_valid), 32'd1);
        @(negedge clk);
        chk("rstbus_v2", 32'(s_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mready = 1'b1;
        chk("rstbus_flags", 32'({s_valid, s_busy, s_done, s_err, s_we}), 32'd0);
        chk("rstbus_addr",  s_addr,  32'd0);
        chk("rstbus_wdata", s_wdata, 32'd0);
        chk("rstbus_rdata", s_rdata, 32'd0);
        model_rdata[0] = 32'd0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rstbus_quiet", 32'({s_valid, s_busy, s_done}), 32'd0);
        end
        mready = 1'b0;

        // Normal operation resumes after reset
        model_rdata[0] = 32'h600D_F00D;
        run_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h600D_F00D, 1'b0, 3, model_rdata[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
